// File: rtl/elevator_motion_ctrl_if.sv
// rtl/elevator_motion_ctrl_if.sv - request/motion signal bundle between request processor and car-motion sequencer
// master: request side, drives allReq_reg/up_need/down_need/door_hold and observes car status
// slave : motion sequencer, observes requests and drives position/ud_mode/state/door_open/timer
interface elevator_motion_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       allReq_reg;
    logic             up_need;
    logic             down_need;
    logic             door_hold;
    logic [3:0]       position;
    logic [1:0]       ud_mode;
    logic [2:0]       state;
    logic             door_open;
    logic [CNT_W-1:0] timer;

    modport master (
        output allReq_reg, up_need, down_need, door_hold,
        input  position, ud_mode, state, door_open, timer
    );

    modport slave (
        input  allReq_reg, up_need, down_need, door_hold,
        output position, ud_mode, state, door_open, timer
    );
endinterface

// File: rtl/elevator_motion_ctrl.sv
// rtl/elevator_motion_ctrl.sv - car-motion sequencer stepping a 4-storey car one floor per travel interval
// clk, rst_n (async active-low); bus.slave: allReq_reg/up_need/down_need/door_hold in,
// position (one-hot), ud_mode (00 stop/01 up/10 down), state (000 stop/001 door/010 move),
// door_open, timer out; all outputs registered
module elevator_motion_ctrl #(
    parameter int MOVE_TICKS = 64,
    parameter int DOOR_TICKS = 96,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    elevator_motion_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_STOP = 3'b000,
        ST_DOOR = 3'b001,
        ST_MOVE = 3'b010
    } state_t;

    localparam logic [1:0] UD_STOP = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DOWN = 2'b10;

    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TICKS - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_TICKS - 1);

    state_t           st_q;
    logic [3:0]       pos_q;
    logic [1:0]       ud_q;
    logic             door_q;
    logic [CNT_W-1:0] timer_q;

    logic       here;
    logic       above;
    logic       below;
    logic [3:0] next_pos;
    logic       req_next;
    logic       beyond_next;
    logic       at_edge;

    assign here  = |(bus.allReq_reg & pos_q);
    assign above = bus.allReq_reg > pos_q;
    assign below = (bus.allReq_reg & (pos_q - 4'd1)) != 4'd0;

    // Floor the car reaches at the next terminal count; the stop decision is taken on
    // this floor so a request still visible now is served before it gets cleared.
    assign next_pos    = (ud_q == UD_UP) ? (pos_q << 1) : (pos_q >> 1);
    assign req_next    = |(bus.allReq_reg & next_pos);
    assign beyond_next = (ud_q == UD_UP) ? (bus.allReq_reg > next_pos)
                                         : ((bus.allReq_reg & (next_pos - 4'd1)) != 4'd0);

    // No floor left in the travel direction (or no direction at all): abandon the move.
    assign at_edge = ((ud_q == UD_UP) && pos_q[3]) ||
                     ((ud_q == UD_DOWN) && pos_q[0]) ||
                     ((ud_q != UD_UP) && (ud_q != UD_DOWN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_STOP;
            pos_q   <= 4'b0001;
            ud_q    <= UD_STOP;
            door_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            case (st_q)
                ST_STOP: begin
                    if (here) begin
                        st_q    <= ST_DOOR;
                        door_q  <= 1'b1;
                        timer_q <= '0;
                    end else if (bus.up_need) begin
                        st_q    <= ST_MOVE;
                        ud_q    <= UD_UP;
                        timer_q <= '0;
                    end else if (bus.down_need) begin
                        st_q    <= ST_MOVE;
                        ud_q    <= UD_DOWN;
                        timer_q <= '0;
                    end
                end
                ST_MOVE: begin
                    door_q <= 1'b0;
                    if (at_edge) begin
                        st_q    <= ST_STOP;
                        ud_q    <= UD_STOP;
                        timer_q <= '0;
                    end else if (timer_q == MOVE_LAST) begin
                        pos_q   <= next_pos;
                        timer_q <= '0;
                        if (req_next) begin
                            st_q   <= ST_DOOR;
                            door_q <= 1'b1;
                        end else if (!beyond_next) begin
                            st_q <= ST_STOP;
                            ud_q <= UD_STOP;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_DOOR: begin
                    if (bus.door_hold) begin
                        door_q  <= 1'b1;
                        timer_q <= '0;
                    end else if (timer_q == DOOR_LAST) begin
                        door_q  <= 1'b0;
                        timer_q <= '0;
                        // ud_mode remembers the travel direction; keep going only if
                        // that direction still has work, otherwise let STOP re-arbitrate.
                        if ((ud_q == UD_UP) && above) begin
                            st_q <= ST_MOVE;
                        end else if ((ud_q == UD_DOWN) && below) begin
                            st_q <= ST_MOVE;
                        end else begin
                            st_q <= ST_STOP;
                            ud_q <= UD_STOP;
                        end
                    end else begin
                        door_q  <= 1'b1;
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    st_q    <= ST_STOP;
                    ud_q    <= UD_STOP;
                    door_q  <= 1'b0;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign bus.position  = pos_q;
    assign bus.ud_mode   = ud_q;
    assign bus.state     = st_q;
    assign bus.door_open = door_q;
    assign bus.timer     = timer_q;
endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// tb/tb_elevator_motion_ctrl.sv - directed self-checking bench for elevator_motion_ctrl
module tb_elevator_motion_ctrl;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    elevator_motion_ctrl_if #(.CNT_W(8)) bus ();

    elevator_motion_ctrl #(
        .MOVE_TICKS(4),
        .DOOR_TICKS(3),
        .CNT_W     (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] pos, input logic [1:0] ud,
                       input logic [2:0] st, input logic door, input logic [7:0] tmr);
        logic [17:0] got;
        logic [17:0] exp;
        got = {bus.position, bus.ud_mode, bus.state, bus.door_open, bus.timer};
        exp = {pos, ud, st, door, tmr};
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got pos=%b ud=%b st=%b door=%b tmr=%0d, expected pos=%b ud=%b st=%b door=%b tmr=%0d",
                   tag, got[17:14], got[13:12], got[11:9], got[8], got[7:0],
                   pos, ud, st, door, tmr);
        end
    endtask

    task automatic set_req(input logic [3:0] req, input logic up, input logic dn);
        bus.allReq_reg = req;
        bus.up_need    = up;
        bus.down_need  = dn;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        set_req(4'b0000, 1'b0, 1'b0);
        bus.door_hold = 1'b0;
        #12;
        chk("reset", 4'b0001, 2'b00, 3'b000, 1'b0, 8'd0);
        rst_n = 1'b1;

        // 1: single trip up to floor 3
        set_req(4'b0100, 1'b1, 1'b0);
        step(1);  chk("t1_move_entry", 4'b0001, 2'b01, 3'b010, 1'b0, 8'd0);
        step(3);  chk("t1_timer3",     4'b0001, 2'b01, 3'b010, 1'b0, 8'd3);
        step(1);  chk("t1_floor2",     4'b0010, 2'b01, 3'b010, 1'b0, 8'd0);
        step(4);  chk("t1_floor3_door",4'b0100, 2'b01, 3'b001, 1'b1, 8'd0);
        set_req(4'b0000, 1'b0, 1'b0);
        step(2);  chk("t1_door_t2",    4'b0100, 2'b01, 3'b001, 1'b1, 8'd2);
        step(1);  chk("t1_stop",       4'b0100, 2'b00, 3'b000, 1'b0, 8'd0);
        step(1);  chk("t1_stop_hold",  4'b0100, 2'b00, 3'b000, 1'b0, 8'd0);

        // 2: request at the current floor opens the door without moving
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        set_req(4'b0001, 1'b0, 1'b0);
        step(1);  chk("t2_door",       4'b0001, 2'b00, 3'b001, 1'b1, 8'd0);
        set_req(4'b0000, 1'b0, 1'b0);
        step(2);  chk("t2_door_t2",    4'b0001, 2'b00, 3'b001, 1'b1, 8'd2);
        step(1);  chk("t2_stop",       4'b0001, 2'b00, 3'b000, 1'b0, 8'd0);

        // 3: intermediate stop at floor 2, then continue to floor 4
        set_req(4'b1010, 1'b1, 1'b0);
        step(1);  chk("t3_move",       4'b0001, 2'b01, 3'b010, 1'b0, 8'd0);
        step(4);  chk("t3_door_f2",    4'b0010, 2'b01, 3'b001, 1'b1, 8'd0);
        set_req(4'b1000, 1'b1, 1'b0);
        step(3);  chk("t3_resume",     4'b0010, 2'b01, 3'b010, 1'b0, 8'd0);
        step(4);  chk("t3_pass_f3",    4'b0100, 2'b01, 3'b010, 1'b0, 8'd0);
        step(4);  chk("t3_door_f4",    4'b1000, 2'b01, 3'b001, 1'b1, 8'd0);
        set_req(4'b0000, 1'b0, 1'b0);
        step(3);  chk("t3_stop",       4'b1000, 2'b00, 3'b000, 1'b0, 8'd0);

        // boundary: spurious up_need at the top floor must not shift past bit3
        set_req(4'b0000, 1'b1, 1'b0);
        step(1);  chk("bnd_move",      4'b1000, 2'b01, 3'b010, 1'b0, 8'd0);
        set_req(4'b0000, 1'b0, 1'b0);
        step(1);  chk("bnd_stop",      4'b1000, 2'b00, 3'b000, 1'b0, 8'd0);

        // 4: go down to floor 3, hold the door for 5 cycles
        set_req(4'b0100, 1'b0, 1'b1);
        step(1);  chk("t4_move_dn",    4'b1000, 2'b10, 3'b010, 1'b0, 8'd0);
        step(4);  chk("t4_door",       4'b0100, 2'b10, 3'b001, 1'b1, 8'd0);
        set_req(4'b0000, 1'b0, 1'b0);
        step(1);  chk("t4_door_t1",    4'b0100, 2'b10, 3'b001, 1'b1, 8'd1);
        bus.door_hold = 1'b1;
        step(5);  chk("t4_held",       4'b0100, 2'b10, 3'b001, 1'b1, 8'd0);
        bus.door_hold = 1'b0;
        step(2);  chk("t4_rel_t2",     4'b0100, 2'b10, 3'b001, 1'b1, 8'd2);
        step(1);  chk("t4_close",      4'b0100, 2'b00, 3'b000, 1'b0, 8'd0);

        // 5: both needs at floor 3 -> up first, then reverse to floor 1
        set_req(4'b1001, 1'b1, 1'b1);
        step(1);  chk("t5_up_wins",    4'b0100, 2'b01, 3'b010, 1'b0, 8'd0);
        step(4);  chk("t5_door_f4",    4'b1000, 2'b01, 3'b001, 1'b1, 8'd0);
        set_req(4'b0001, 1'b0, 1'b1);
        step(3);  chk("t5_stop",       4'b1000, 2'b00, 3'b000, 1'b0, 8'd0);
        step(1);  chk("t5_move_dn",    4'b1000, 2'b10, 3'b010, 1'b0, 8'd0);
        step(4);  chk("t5_f3",         4'b0100, 2'b10, 3'b010, 1'b0, 8'd0);
        step(4);  chk("t5_f2",         4'b0010, 2'b10, 3'b010, 1'b0, 8'd0);
        step(4);  chk("t5_door_f1",    4'b0001, 2'b10, 3'b001, 1'b1, 8'd0);
        set_req(4'b0000, 1'b0, 1'b0);
        step(3);  chk("t5_stop_f1",    4'b0001, 2'b00, 3'b000, 1'b0, 8'd0);

        // 6: asynchronous reset in the middle of a move
        set_req(4'b0100, 1'b1, 1'b0);
        step(1);
        step(4);  chk("t6_f2",         4'b0010, 2'b01, 3'b010, 1'b0, 8'd0);
        step(2);  chk("t6_timer2",     4'b0010, 2'b01, 3'b010, 1'b0, 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst", 4'b0001, 2'b00, 3'b000, 1'b0, 8'd0);
        set_req(4'b0000, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        step(1);  chk("t6_after_rst",  4'b0001, 2'b00, 3'b000, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
